// File: rtl/voice_osc_bank.sv
// Four divider-driven 8-bit phase accumulators feeding one shared quarter-wave sine ROM.
// The ROM is time-multiplexed, so one sample register is refreshed per cycle in round-robin order.
module voice_osc_bank (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [12:0] divider1,
  input  logic [10:0] divider2,
  input  logic [10:0] divider3,
  input  logic [10:0] divider4,
  output logic [6:0]  sample1,
  output logic [6:0]  sample2,
  output logic [6:0]  sample3,
  output logic [6:0]  sample4,
  output logic        frame
);

  localparam logic [6:0] MIDSCALE = 7'd64;

  // q(i) = floor(63.5 * sin(2*pi*i/256)), i = 0..63
  localparam logic [5:0] QROM [0:63] = '{
    6'd0,  6'd1,  6'd3,  6'd4,  6'd6,  6'd7,  6'd9,  6'd10,
    6'd12, 6'd13, 6'd15, 6'd16, 6'd18, 6'd19, 6'd21, 6'd22,
    6'd24, 6'd25, 6'd27, 6'd28, 6'd29, 6'd31, 6'd32, 6'd33,
    6'd35, 6'd36, 6'd37, 6'd39, 6'd40, 6'd41, 6'd42, 6'd43,
    6'd44, 6'd45, 6'd47, 6'd48, 6'd49, 6'd50, 6'd51, 6'd51,
    6'd52, 6'd53, 6'd54, 6'd55, 6'd56, 6'd56, 6'd57, 6'd58,
    6'd58, 6'd59, 6'd59, 6'd60, 6'd60, 6'd61, 6'd61, 6'd61,
    6'd62, 6'd62, 6'd62, 6'd63, 6'd63, 6'd63, 6'd63, 6'd63
  };

  logic [12:0] div [4];
  logic [12:0] cnt [4];
  logic [7:0]  ph  [4];
  logic [6:0]  smp [4];
  logic [1:0]  slot;
  logic [7:0]  rd_ph;
  logic [5:0]  rom_addr;
  logic [5:0]  rom_q;
  logic [6:0]  conv;

  assign div[0] = divider1;
  assign div[1] = {2'b00, divider2};
  assign div[2] = {2'b00, divider3};
  assign div[3] = {2'b00, divider4};

  // The >= compare lets a shrinking divider take effect on the very next edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int v = 0; v < 4; v++) begin
        cnt[v] <= '0;
        ph[v]  <= '0;
      end
    end else begin
      for (int v = 0; v < 4; v++) begin
        if (div[v] == 13'd0) begin
          cnt[v] <= '0;
          ph[v]  <= '0;
        end else if (cnt[v] >= div[v] - 13'd1) begin
          cnt[v] <= '0;
          ph[v]  <= ph[v] + 8'd1;
        end else begin
          cnt[v] <= cnt[v] + 13'd1;
        end
      end
    end
  end

  // Odd quadrants read the ROM mirrored; the upper half-wave is reflected about midscale.
  always_comb begin
    rd_ph    = ph[slot];
    rom_addr = rd_ph[6] ? ~rd_ph[5:0] : rd_ph[5:0];
    rom_q    = QROM[rom_addr];
    conv     = rd_ph[7] ? (MIDSCALE - {1'b0, rom_q}) : (MIDSCALE + {1'b0, rom_q});
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int v = 0; v < 4; v++) smp[v] <= MIDSCALE;
      slot  <= 2'd0;
      frame <= 1'b0;
    end else begin
      smp[slot] <= conv;
      slot      <= slot + 2'd1;
      frame     <= (slot == 2'd3);
    end
  end

  assign sample1 = smp[0];
  assign sample2 = smp[1];
  assign sample3 = smp[2];
  assign sample4 = smp[3];

endmodule

// File: doc/voice_osc_bank.md
# voice_osc_bank

Four-voice divider-driven sine oscillator bank sitting directly downstream of the music sequencer and upstream of the PWM audio stage. Each cycle it consumes one 13-bit cello divider and three 11-bit violin dividers, advances four 8-bit phase accumulators, and converts the phases to 7-bit unsigned sine samples through one shared, time-multiplexed quarter-wave ROM. A divider of 0 mutes the voice at midscale (64), which matches the sequencer's rest convention.

## Interface
- Parameters: none; all widths are fixed.
- clk  in  1  project clock, 30 MHz
- rst_n  in  1  reset, synchronous, active-low
- divider1  in  13  voice 1 (cello) step period in clk cycles; 0 = mute
- divider2, divider3, divider4  in  11 each  voices 2-4 (violin) step periods; 0 = mute
- sample1..sample4  out  7 each  unsigned sine samples, midscale 64, registered
- frame  out  1  one-cycle pulse, asserted in the cycle after sample4 is rewritten

## Operation
- Per voice v: 13-bit tick counter cnt[v] and 8-bit phase ph[v]. Voices 2-4 zero-extend their divider to 13 bits.
- Each cycle with divider d != 0:
  - If cnt >= d-1: cnt <= 0, ph <= ph+1 (wraps 255->0).
  - Otherwise cnt <= cnt+1.
  - The >= compare applies a shrinking divider immediately. Example: cnt=1000 with d changed to 500 gives a wrap and one phase step on the next edge.
- d == 1: phase steps every cycle. d == 0: cnt <= 0, ph <= 0 (mute). Leaving mute starts from phase 0, cnt 0.
- Quarter-wave ROM: 64 entries, q(i) = floor(63.5*sin(2*pi*i/256)), so q(0)=0 and q(63)=63. Combinational read.
- Phase to sample, with quadrant = ph[7:6] and i = ph[5:0]:
  - Q0: 64 + q(i)
  - Q1: 64 + q(~i)
  - Q2: 64 - q(i)
  - Q3: 64 - q(~i)
  - Result range 1..127, 7 bits, no clamp needed.
- Reference points: ph=0 -> 64, ph=64 -> 127, ph=128 -> 64, ph=192 -> 1.
- Round-robin slot counter slot[1:0], 0->1->2->3->0 every cycle:
  - The ROM address is taken from ph[slot+1] as it stands before that edge.
  - The converted result is written to sample{slot+1} on the edge.
  - Only one sample register changes per cycle.
- frame <= (slot == 3), registered.

## Timing
- Reset (rst_n low at an edge):
  - All cnt = 0, ph = 0, slot = 0.
  - sample1..4 = 64, frame = 0.
  - Reset mid-operation takes effect at the next edge regardless of state.
- First edge with rst_n high:
  - slot 0 -> sample1 written; the phase update happens on the same edge.
  - Cycle N after reset release writes sample((N mod 4)+1).
- frame is high during cycles 4, 8, 12, ... after reset release, counting from the first edge with rst_n high as cycle 1.
- Latency from a phase change to the sample output: 1-4 cycles, depending on the slot position.
- Each sample is refreshed every 4 cycles. Sample rate per voice is 7.5 MHz, far above the step rate; the minimum practical divider is 1.
- Divider inputs are sampled every cycle with no handshake. A change on cycle t affects the cnt/ph update at the edge ending cycle t.
- Voice period = 256 * d cycles. d=1595 -> 408,320 cycles, 73.47 Hz.
- Simultaneous wrap on all voices: all four phases step independently on the same edge; no arbitration is needed.

## Test plan
- Reset: hold rst_n low 3 cycles with all dividers nonzero -> sample1..4 = 64, frame = 0; after release, frame pulses on cycles 4, 8, 12.
- divider2 = 1, others 0:
  - ph2 steps every cycle.
  - sample2 reads 127 within 4 cycles of ph2 = 64 and reads 1 near ph2 = 192.
  - sample1, sample3, sample4 stay at 64.
- divider1 = 1595:
  - Exactly one ph1 increment per 1595 cycles.
  - ph1 returns to 0 after 408,320 cycles.
  - sample1 follows the Q0-Q3 mapping at ph1 = 32, 96, 160, 224.
- Shrink mid-count:
  - divider3 = 1000, wait until cnt3 = 800, set divider3 = 500 -> wrap on the next edge, one ph3 step, subsequent steps every 500 cycles.
  - Growing to 2000 at cnt3 = 800 -> next step 1200 cycles later.
- Mute: with divider4 = 421 running at ph4 = 100, set divider4 = 0 -> ph4 = 0 next edge and sample4 = 64 within 4 cycles; restore 421 -> first step 421 cycles later.
- Reset mid-operation: assert rst_n low for 1 cycle with all voices running -> all samples = 64, slot restarts at 0, phase counting resumes from 0.
